// File: rtl/multi_cycle_datapath_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : multi_cycle_datapath_if
//  Description : Shared instruction/data memory port for multi_cycle_datapath.
//                A single req/ready handshake carries fetches, loads and stores.
//                An access completes on the rising edge where mem_req and
//                mem_ready are both high.
//  Ports       : mem_req   core -> mem  access request
//                mem_we    core -> mem  1 = write (sw), 0 = read (fetch, lw)
//                mem_addr  core -> mem  byte address (low 2 bits unmodified)
//                mem_wdata core -> mem  store data
//                mem_ready mem -> core  access completes this cycle
//                mem_rdata mem -> core  read data, valid with mem_ready
//  Revision    : 1.0  initial release
// ============================================================================
interface multi_cycle_datapath_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic                  mem_ready;
   logic [31:0]           mem_rdata;

   // Core side
   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   // Memory side
   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_datapath.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : multi_cycle_datapath
//  Description : Multi-cycle MIPS-32 integer core (add sub and or slt addi slti
//                andi ori lw sw beq bne j). Every instruction walks through
//                FETCH/DECODE/EXEC/MEM/WB over one shared memory port that
//                tolerates wait states. Illegal encodings park the core in HALT.
//  Ports       : clock   single rising-edge clock
//                clear   synchronous active-high reset
//                mem     memory bus (master modport of multi_cycle_datapath_if)
//                pc_out  current PC register
//                retire  pulse in the final cycle of each completed instruction
//                halted  high while in HALT
//  Parameters  : ADDR_WIDTH  PC / byte-address width (up to 32)
//                RESET_PC    word-aligned PC loaded by clear
//  Revision    : 1.0  initial release
// ============================================================================
module multi_cycle_datapath #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  wire logic                  clock,
   input  wire logic                  clear,
   multi_cycle_datapath_if.master     mem,
   output logic [ADDR_WIDTH-1:0]      pc_out,
   output logic                       retire,
   output logic                       halted
);

   // ------------------------------------------------------------------------
   // Encodings
   // ------------------------------------------------------------------------
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_ADD    = 6'b100000;
   localparam logic [5:0] F_SUB    = 6'b100010;
   localparam logic [5:0] F_AND    = 6'b100100;
   localparam logic [5:0] F_OR     = 6'b100101;
   localparam logic [5:0] F_SLT    = 6'b101010;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   // ------------------------------------------------------------------------
   // Architectural and micro-architectural state
   // ------------------------------------------------------------------------
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] t_q;        // branch target computed in DECODE
   logic [31:0]           ir_q;
   logic [31:0]           a_q;
   logic [31:0]           b_q;
   logic [31:0]           aluout_q;
   logic [31:0]           mdr_q;
   logic [31:0]           rf_q [32];

   // ------------------------------------------------------------------------
   // Instruction fields and decode
   // ------------------------------------------------------------------------
   logic [5:0]            w_op;
   logic [5:0]            w_funct;
   logic [4:0]            w_rs, w_rt, w_rd, w_dest;
   logic [31:0]           w_imm_sext, w_imm_zext, w_alu_b, w_alu_res, w_wb_data;
   logic [31:0]           w_br_off32;
   logic [ADDR_WIDTH-1:0] w_jump_target;
   logic                  w_legal, w_is_mem, w_is_ctl, w_br_take, w_done;

   assign w_op       = ir_q[31:26];
   assign w_funct    = ir_q[5:0];
   assign w_rs       = ir_q[25:21];
   assign w_rt       = ir_q[20:16];
   assign w_rd       = ir_q[15:11];
   assign w_dest     = (w_op == OP_RTYPE) ? w_rd : w_rt;
   assign w_imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
   assign w_imm_zext = {16'h0000, ir_q[15:0]};
   assign w_br_off32 = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
   assign w_is_mem   = (w_op == OP_LW) || (w_op == OP_SW);
   assign w_is_ctl   = (w_op == OP_BEQ) || (w_op == OP_BNE) || (w_op == OP_J);
   assign w_br_take  = (w_op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
   assign w_wb_data  = (w_op == OP_LW) ? mdr_q : aluout_q;

   // Jump keeps the PC bits above the 28-bit region; narrow PCs simply
   // truncate the region address.
   if (ADDR_WIDTH > 28) begin : g_jump_wide
      assign w_jump_target = {pc_q[ADDR_WIDTH-1:28], ir_q[25:0], 2'b00};
   end else begin : g_jump_narrow
      assign w_jump_target = ADDR_WIDTH'({ir_q[25:0], 2'b00});
   end

   always_comb begin
      w_legal = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            case (w_funct)
               F_ADD, F_SUB, F_AND, F_OR, F_SLT: w_legal = 1'b1;
               default:                          w_legal = 1'b0;
            endcase
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
         OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J:    w_legal = 1'b1;
         default:                               w_legal = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------------
   // ALU: andi/ori zero-extend, the other immediates sign-extend
   // ------------------------------------------------------------------------
   assign w_alu_b = (w_op == OP_RTYPE)                      ? b_q        :
                    ((w_op == OP_ANDI) || (w_op == OP_ORI)) ? w_imm_zext :
                                                              w_imm_sext;

   always_comb begin
      w_alu_res = a_q + w_alu_b;
      if (w_op == OP_RTYPE) begin
         case (w_funct)
            F_SUB:   w_alu_res = a_q - w_alu_b;
            F_AND:   w_alu_res = a_q & w_alu_b;
            F_OR:    w_alu_res = a_q | w_alu_b;
            F_SLT:   w_alu_res = {31'd0, ($signed(a_q) < $signed(w_alu_b))};
            default: w_alu_res = a_q + w_alu_b;
         endcase
      end else begin
         case (w_op)
            OP_SLTI: w_alu_res = {31'd0, ($signed(a_q) < $signed(w_alu_b))};
            OP_ANDI: w_alu_res = a_q & w_alu_b;
            OP_ORI:  w_alu_res = a_q | w_alu_b;
            default: w_alu_res = a_q + w_alu_b;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (mem.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (ir_q == 32'd0)    state_d = S_FETCH;
            else if (!w_legal)    state_d = S_HALT;
            else                  state_d = S_EXEC;
         end
         S_EXEC: begin
            if (w_is_mem)         state_d = S_MEM;
            else if (w_is_ctl)    state_d = S_FETCH;
            else                  state_d = S_WB;
         end
         S_MEM: begin
            if (mem.mem_ready) state_d = (w_op == OP_SW) ? S_FETCH : S_WB;
         end
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers. rf_q[0] is never written, so it always reads 0.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (clear) begin
         pc_q     <= RESET_PC;
         t_q      <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
         mdr_q    <= '0;
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem.mem_ready) begin
                  ir_q <= mem.mem_rdata;
                  pc_q <= pc_q + ADDR_WIDTH'(4);
               end
            end
            S_DECODE: begin
               a_q <= rf_q[w_rs];
               b_q <= rf_q[w_rt];
               // pc_q already holds PC+4 here
               t_q <= pc_q + w_br_off32[ADDR_WIDTH-1:0];
            end
            S_EXEC: begin
               if (w_is_mem) begin
                  aluout_q <= a_q + w_imm_sext;
               end else if (w_op == OP_J) begin
                  pc_q <= w_jump_target;
               end else if (w_is_ctl) begin
                  if (w_br_take) pc_q <= t_q;
               end else begin
                  aluout_q <= w_alu_res;
               end
            end
            S_MEM: begin
               if (mem.mem_ready && (w_op == OP_LW)) mdr_q <= mem.mem_rdata;
            end
            S_WB: begin
               if (w_dest != 5'd0) rf_q[w_dest] <= w_wb_data;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs decoded from registered state. Store data and address come from
   // registers that are frozen for the whole access, so they stay stable
   // across wait states. A store retires in the cycle its handshake completes.
   // ------------------------------------------------------------------------
   assign mem.mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
   assign mem.mem_we    = (state_q == S_MEM) && (w_op == OP_SW);
   assign mem.mem_addr  = (state_q == S_MEM) ? aluout_q[ADDR_WIDTH-1:0] : pc_q;
   assign mem.mem_wdata = b_q;

   assign w_done = ((state_q == S_DECODE) && (ir_q == 32'd0))             ||
                   ((state_q == S_EXEC)   && w_is_ctl)                    ||
                   ((state_q == S_MEM)    && (w_op == OP_SW) && mem.mem_ready) ||
                   (state_q == S_WB);

   // clear cancels whatever would have completed this cycle
   assign retire = w_done && !clear;
   assign halted = (state_q == S_HALT);
   assign pc_out = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_datapath.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_multi_cycle_datapath
//  Description : Self-checking bench. A word memory model with programmable
//                wait states answers the core; every expected bus access is
//                queued when a program is loaded and popped as accesses finish.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_cycle_datapath;
   localparam int AW = 32;

   logic          clock = 1'b0;
   logic          clear = 1'b1;
   logic [AW-1:0] pc_out;
   logic          retire;
   logic          halted;

   multi_cycle_datapath_if #(.ADDR_WIDTH(AW)) bus ();

   multi_cycle_datapath #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
      .clock  (clock),
      .clear  (clear),
      .mem    (bus),
      .pc_out (pc_out),
      .retire (retire),
      .halted (halted)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } acc_t;

   acc_t        sb[$];
   logic [31:0] mem [0:255];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          waits = 0;
   int          wcnt  = 0;
   int          retires = 0;
   logic        stall_prev = 1'b0;
   logic [31:0] stall_addr, stall_wdata;
   logic        stall_we;

   localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

   function automatic logic [31:0] r_op(int rs, int rt, int rd, logic [5:0] f);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
   endfunction

   function automatic logic [31:0] i_op(logic [5:0] op, int rs, int rt, int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   task automatic exp_rd(input logic [31:0] a);
      acc_t e;
      e.we = 1'b0; e.addr = a; e.wdata = 32'h0;
      sb.push_back(e);
   endtask

   task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
      acc_t e;
      e.we = 1'b1; e.addr = a; e.wdata = d;
      sb.push_back(e);
   endtask

   task automatic mem_clear();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   // One clock cycle: answer the bus, then score what the edge completed.
   task automatic step();
      logic        e_req, e_ready, e_clear, e_we, e_ret;
      logic [31:0] e_addr, e_wdata;
      acc_t        exp_a;
      if (stall_prev) begin
         n_cmp++;
         if (bus.mem_req !== 1'b1 || bus.mem_addr !== stall_addr ||
             bus.mem_we !== stall_we || bus.mem_wdata !== stall_wdata) begin
            n_bad++;
            $display("FAIL req_stable: got req=%b addr=%h we=%b wd=%h want req=1 addr=%h we=%b wd=%h",
                     bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata,
                     stall_addr, stall_we, stall_wdata);
         end
      end
      if (bus.mem_req === 1'b1 && wcnt >= waits) begin
         bus.mem_ready = 1'b1;
         bus.mem_rdata = mem[bus.mem_addr[9:2]];
      end else begin
         bus.mem_ready = 1'b0;
         bus.mem_rdata = 32'h0;
      end
      #1;
      e_req = bus.mem_req; e_ready = bus.mem_ready; e_clear = clear;
      e_we = bus.mem_we; e_addr = bus.mem_addr; e_wdata = bus.mem_wdata;
      e_ret = retire;
      @(posedge clock);
      #1;
      if (e_req === 1'b1 && e_ready && !e_clear) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL access_unexpected: got we=%b addr=%h wd=%h want none", e_we, e_addr, e_wdata);
         end else begin
            exp_a = sb.pop_front();
            if (e_we !== exp_a.we || e_addr !== exp_a.addr ||
                (exp_a.we && e_wdata !== exp_a.wdata)) begin
               n_bad++;
               $display("FAIL access: got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                        e_we, e_addr, e_wdata, exp_a.we, exp_a.addr, exp_a.wdata);
            end
         end
         if (e_we === 1'b1) mem[e_addr[9:2]] = e_wdata;
      end
      if (e_ret === 1'b1) retires++;
      stall_prev  = (e_req === 1'b1) && !e_ready && !e_clear;
      stall_addr  = e_addr; stall_we = e_we; stall_wdata = e_wdata;
      if (e_clear || e_req !== 1'b1 || e_ready) wcnt = 0;
      else wcnt++;
   endtask

   // Reset, release, and step into the first FETCH cycle.
   task automatic start_cpu();
      clear = 1'b1;
      step(); step();
      clear = 1'b0;
      step();
      retires = 0;
   endtask

   task automatic run_to_halt(input string name, input int limit);
      for (int i = 0; i < limit && halted !== 1'b1; i++) step();
      n_cmp++;
      if (halted !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_halt_timeout: got halted=%b want 1", name, halted);
      end
   endtask

   task automatic check_retires(input string name, input int want);
      n_cmp++;
      if (retires != want) begin
         n_bad++;
         $display("FAIL %s_retires: got %0d want %0d", name, retires, want);
      end
   endtask

   task automatic end_test(input string name);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL %s_leftover: got %0d pending accesses want 0", name, sb.size());
      end
      sb.delete();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      waits = 0; mem_clear(); mem[0] = ILLEGAL;
      clear = 1'b1;
      step(); step();
      n_cmp++;
      if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 ||
          bus.mem_wdata !== 32'h0 || pc_out !== 32'h0 || retire !== 1'b0 || halted !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h pc=%h ret=%b hlt=%b want all 0",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, pc_out, retire, halted);
      end
      clear = 1'b0;
      n_cmp++;
      if (bus.mem_req !== 1'b0 || pc_out !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_idle: got req=%b pc=%h want req=0 pc=0", bus.mem_req, pc_out);
      end
      step();
      n_cmp++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0) begin
         n_bad++;
         $display("FAIL first_fetch: got req=%b we=%b addr=%h want req=1 we=0 addr=0",
                  bus.mem_req, bus.mem_we, bus.mem_addr);
      end
      // clear coincides with ready: the fetch must be discarded
      clear = 1'b1;
      step();
      n_cmp++;
      if (pc_out !== 32'h0 || bus.mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_beats_ready: got pc=%h req=%b want pc=0 req=0", pc_out, bus.mem_req);
      end
      end_test("reset");
   endtask

   task automatic test_alu();
      waits = 0; mem_clear();
      mem[0] = i_op(6'h08, 0, 1, 5);             // addi $1,$0,5
      mem[1] = i_op(6'h08, 0, 2, -3);            // addi $2,$0,-3
      mem[2] = r_op(1, 2, 3, 6'h20);             // add  $3,$1,$2
      mem[3] = r_op(2, 1, 4, 6'h2A);             // slt  $4,$2,$1
      mem[4] = i_op(6'h2B, 0, 3, 32'h80);        // sw   $3,0x80($0)
      mem[5] = i_op(6'h2B, 0, 4, 32'h84);        // sw   $4,0x84($0)
      mem[6] = ILLEGAL;
      exp_rd(32'h00); exp_rd(32'h04); exp_rd(32'h08); exp_rd(32'h0C);
      exp_rd(32'h10); exp_wr(32'h80, 32'd2);
      exp_rd(32'h14); exp_wr(32'h84, 32'd1);
      exp_rd(32'h18);
      start_cpu();
      for (int i = 0; i < 15; i++) step();
      check_retires("alu_15cyc", 3);
      step();
      check_retires("alu_16cyc", 4);
      run_to_halt("alu", 40);
      check_retires("alu_total", 6);
      end_test("alu");
   endtask

   task automatic test_wait();
      waits = 2; mem_clear();
      mem[0] = i_op(6'h23, 0, 5, 8);             // lw $5,8($0)
      mem[1] = i_op(6'h2B, 0, 5, 32'h88);        // sw $5,0x88($0)
      mem[2] = 32'hDEAD_BEEF;                    // data; opcode 110111 halts if fetched
      exp_rd(32'h00); exp_rd(32'h08); exp_rd(32'h04);
      exp_wr(32'h88, 32'hDEAD_BEEF); exp_rd(32'h08);
      start_cpu();
      for (int i = 0; i < 8; i++) step();
      check_retires("lw_wait_8cyc", 0);
      step();
      check_retires("lw_wait_9cyc", 1);
      run_to_halt("wait", 80);
      end_test("wait");
   endtask

   task automatic test_store();
      waits = 0; mem_clear();
      mem[0] = i_op(6'h08, 0, 3, 2);             // addi $3,$0,2
      mem[1] = i_op(6'h2B, 0, 3, 12);            // sw $3,12($0) -> word 3 = 0x2 (illegal funct)
      mem[2] = i_op(6'h2B, 0, 3, 32'h90);        // sw $3,0x90($0): $3 must still be 2
      exp_rd(32'h00); exp_rd(32'h04); exp_wr(32'h0C, 32'd2);
      exp_rd(32'h08); exp_wr(32'h90, 32'd2); exp_rd(32'h0C);
      start_cpu();
      for (int i = 0; i < 7; i++) step();
      check_retires("sw_7cyc", 1);
      step();
      check_retires("sw_8cyc", 2);
      run_to_halt("store", 40);
      check_retires("store_total", 3);
      end_test("store");
   endtask

   task automatic test_branch();
      waits = 0; mem_clear();
      mem[0]    = i_op(6'h08, 0, 1, 7);          // addi $1,$0,7
      mem[1]    = i_op(6'h08, 0, 2, 7);          // addi $2,$0,7
      mem[2]    = i_op(6'h08, 0, 0, 9);          // addi $0,$0,9 (discarded)
      mem[3]    = 32'h0;                         // nop
      mem[4]    = i_op(6'h04, 1, 2, 3);          // 0x10 beq taken -> 0x20
      mem[5]    = ILLEGAL; mem[6] = ILLEGAL; mem[7] = ILLEGAL;
      mem[8]    = i_op(6'h05, 1, 2, 5);          // 0x20 bne not taken -> 0x24
      mem[9]    = {6'h02, 26'h40};               // 0x24 j -> 0x100
      mem[10]   = ILLEGAL;
      mem[8'h40] = i_op(6'h2B, 0, 0, 32'h94);    // 0x100 sw $0,0x94($0)
      mem[8'h41] = i_op(6'h05, 1, 0, 1);         // 0x104 bne taken -> 0x10C
      mem[8'h42] = ILLEGAL;
      mem[8'h43] = ILLEGAL;                      // 0x10C
      exp_rd(32'h00); exp_rd(32'h04); exp_rd(32'h08); exp_rd(32'h0C);
      exp_rd(32'h10); exp_rd(32'h20); exp_rd(32'h24); exp_rd(32'h100);
      exp_wr(32'h94, 32'h0); exp_rd(32'h104); exp_rd(32'h10C);
      start_cpu();
      for (int i = 0; i < 13; i++) step();
      check_retires("nop_13cyc", 3);
      step();
      check_retires("nop_14cyc", 4);
      step(); step();
      check_retires("beq_16cyc", 4);
      step();
      check_retires("beq_17cyc", 5);
      run_to_halt("branch", 80);
      check_retires("branch_total", 9);
      end_test("branch");
   endtask

   task automatic test_illegal();
      int bad_req;
      waits = 0; mem_clear();
      mem[0] = ILLEGAL;
      exp_rd(32'h00);
      start_cpu();
      step();
      n_cmp++;
      if (halted !== 1'b0) begin
         n_bad++;
         $display("FAIL illegal_cyc2: got halted=%b want 0", halted);
      end
      step();
      n_cmp++;
      if (halted !== 1'b1) begin
         n_bad++;
         $display("FAIL illegal_cyc3: got halted=%b want 1", halted);
      end
      bad_req = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.mem_req !== 1'b0 || halted !== 1'b1) bad_req++;
         step();
      end
      n_cmp++;
      if (bad_req != 0) begin
         n_bad++;
         $display("FAIL halt_quiet: got %0d cycles with req/halt wrong want 0", bad_req);
      end
      check_retires("illegal", 0);
      end_test("illegal");
   endtask

   task automatic test_clear_mid();
      waits = 3; mem_clear();
      mem[0] = i_op(6'h23, 0, 6, 32'h40);        // lw $6,0x40($0)
      exp_rd(32'h00);
      start_cpu();
      for (int i = 0; i < 7; i++) step();        // FETCH x4, DECODE, EXEC, MEM(1)
      n_cmp++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h40) begin
         n_bad++;
         $display("FAIL mem_stalled: got req=%b we=%b addr=%h want req=1 we=0 addr=40",
                  bus.mem_req, bus.mem_we, bus.mem_addr);
      end
      clear = 1'b1;
      step();
      n_cmp++;
      if (bus.mem_req !== 1'b0 || pc_out !== 32'h0 || retire !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_mid: got req=%b pc=%h ret=%b want req=0 pc=0 ret=0",
                  bus.mem_req, pc_out, retire);
      end
      clear = 1'b0;
      step();
      n_cmp++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0) begin
         n_bad++;
         $display("FAIL refetch: got req=%b addr=%h we=%b want req=1 addr=0 we=0",
                  bus.mem_req, bus.mem_addr, bus.mem_we);
      end
      clear = 1'b1;
      step();
      end_test("clear_mid");
   endtask

   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      test_reset();
      test_alu();
      test_wait();
      test_store();
      test_branch();
      test_illegal();
      test_clear_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
